// File: rtl/adc_serial_rx.sv
// adc_serial_rx
// Far-end receiver for the ADC controller's serial result link. It collects one
// MSB-first frame while data_mark is high, expects exactly N bits followed by a
// load_reg commit strobe within LD_TIMEOUT cycles, and hands the word to the
// consumer on a valid/ready port. Bad frames raise a one-cycle frame_err.
// A good frame that arrives while the output is still full raises a one-cycle
// overrun, and that word is dropped.

module adc_serial_rx #(
    parameter int N          = 8,
    parameter int LD_TIMEOUT = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         serial_in,
    input  logic         data_mark,
    input  logic         load_reg,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic [15:0]  word_cnt
);

    // Receiver states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] WAIT_LD = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    // bit_cnt must be able to hold N itself; timer covers LD_TIMEOUT up to 15
    localparam int               CNT_W     = $clog2(N + 1);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] BITS_ONE  = CNT_W'(1);
    localparam logic [3:0]       TMO       = 4'(LD_TIMEOUT);

    logic [1:0]       state_q,    state_d;
    logic [N-1:0]     shift_q,    shift_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [3:0]       timer_q,    timer_d;
    logic [N-1:0]     dout_q,     dout_d;
    logic             valid_q,    valid_d;
    logic             ferr_q,     ferr_d;
    logic             ovr_q,      ovr_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    // Raised for one cycle when a complete frame sees its load_reg strobe
    logic             commit;

    // Frame tracking: shift bits in, check length and the commit window
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        commit    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A stray load_reg here has no frame behind it and is ignored
                if (data_mark) begin
                    shift_d   = {shift_q[N-2:0], serial_in};
                    bit_cnt_d = BITS_ONE;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (data_mark) begin
                    if (bit_cnt_q == BITS_FULL) begin
                        // One bit too many: discard and wait for the mark to drop
                        ferr_d  = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        shift_d   = {shift_q[N-2:0], serial_in};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (bit_cnt_q == BITS_FULL) begin
                    timer_d = '0;
                    if (load_reg) begin
                        // Strobe already present in the first low cycle
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_LD;
                    end
                end else begin
                    // Mark dropped before N bits arrived
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            WAIT_LD: begin
                if (load_reg) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (data_mark) begin
                    // New frame started before the commit; its first bit is dropped
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q + 4'd1 == TMO) begin
                    ferr_d  = 1'b1;
                    timer_d = timer_q + 4'd1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end

            DRAIN: begin
                if (!data_mark) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output port: load on commit when there is room, otherwise flag overrun
    always_comb begin
        dout_d     = dout_q;
        valid_d    = valid_q;
        word_cnt_d = word_cnt_q;
        ovr_d      = 1'b0;

        if (commit) begin
            // A consumer taking the old word in this cycle frees the slot
            if (!valid_q || dout_ready) begin
                dout_d     = shift_q;
                valid_d    = 1'b1;
                word_cnt_d = word_cnt_q + 16'd1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Testbench for adc_serial_rx: directed frames followed by randomized frames,
// checked against a frame-level reference model.

module tb_adc_serial_rx;

    localparam int N     = 8;
    localparam int LD_TO = 4;

    logic         clk        = 1'b0;
    logic         clr        = 1'b0;
    logic         serial_in  = 1'b0;
    logic         data_mark  = 1'b0;
    logic         load_reg   = 1'b0;
    logic         dout_ready = 1'b0;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         overrun;
    logic [15:0]  word_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Per-transaction observations
    int   err_n;
    int   ovr_n;
    int   err_at;
    int   pos;
    logic valid_after_bits;

    // Reference model: what the consumer should see
    logic         m_valid;
    logic [N-1:0] m_dout;
    logic [15:0]  m_cnt;

    adc_serial_rx #(.N(N), .LD_TIMEOUT(LD_TO)) dut (
        .clk        (clk),
        .clr        (clr),
        .serial_in  (serial_in),
        .data_mark  (data_mark),
        .load_reg   (load_reg),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and observe the edge that samples them
    task automatic cyc(input logic dm, input logic si, input logic ld, input logic rdy);
        data_mark  = dm;
        serial_in  = si;
        load_reg   = ld;
        dout_ready = rdy;
        @(negedge clk);
        if (frame_err === 1'b1) begin
            err_n++;
            err_at = pos;
        end
        if (overrun === 1'b1) ovr_n++;
        chk("err_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
    endtask

    // nbits of data_mark high, then nlow low cycles with load_reg at low index ld_at
    task automatic run_frame(input logic [15:0] bits, input int nbits, input int nlow,
                             input int ld_at, input logic rdy);
        err_n  = 0;
        ovr_n  = 0;
        err_at = -1;
        for (int i = 0; i < nbits; i++) begin
            pos = i;
            cyc(1'b1, bits[nbits-1-i], 1'b0, 1'b0);
        end
        valid_after_bits = dout_valid;
        for (int c = 0; c < nlow; c++) begin
            pos = 100 + c;
            cyc(1'b0, 1'($urandom), (c == ld_at), (c == ld_at) ? rdy : 1'b0);
        end
    endtask

    // kind: 0 good, 1 short, 2 long, 3 load timeout
    task automatic do_frame(input int kind, input logic [N-1:0] word, input int ld_at,
                            input logic rdy);
        logic [15:0] bits;
        int          nb;
        logic        exp_ovr;
        bits    = 16'($urandom);
        exp_ovr = 1'b0;
        case (kind)
            0: begin
                bits[N-1:0] = word;
                run_frame(bits, N, ld_at + 1, ld_at, rdy);
                if (!m_valid || rdy) begin
                    m_dout  = word;
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 16'd1;
                end else begin
                    exp_ovr = 1'b1;
                end
                chk("good_frame_err", err_n, 0);
                chk("good_overrun", ovr_n, {31'd0, exp_ovr});
            end
            1: begin
                nb = $urandom_range(N - 1, 1);
                run_frame(bits, nb, 1, ($urandom_range(1, 0) == 1) ? 0 : -1, 1'b0);
                chk("short_err_count", err_n, 1);
                chk("short_err_at", err_at, 100);
                chk("short_overrun", ovr_n, 0);
            end
            2: begin
                nb = $urandom_range(N + 4, N + 1);
                run_frame(bits, nb, 1, -1, 1'b0);
                chk("long_err_count", err_n, 1);
                chk("long_err_at", err_at, N);
                chk("long_overrun", ovr_n, 0);
            end
            default: begin
                bits[N-1:0] = word;
                run_frame(bits, N, LD_TO + 2, -1, 1'b0);
                chk("tmo_err_count", err_n, 1);
                chk("tmo_err_at", err_at, 100 + LD_TO);
                chk("tmo_overrun", ovr_n, 0);
            end
        endcase
        chk("frame_dout", {24'd0, dout}, {24'd0, m_dout});
        chk("frame_valid", {31'd0, dout_valid}, {31'd0, m_valid});
        chk("frame_word_cnt", {16'd0, word_cnt}, {16'd0, m_cnt});
    endtask

    // One idle cycle; a stray load_reg must be ignored, ready may consume
    task automatic idle(input logic rdy);
        err_n = 0;
        ovr_n = 0;
        pos   = 200;
        cyc(1'b0, 1'($urandom), 1'($urandom), rdy);
        if (m_valid && rdy) m_valid = 1'b0;
        chk("idle_err", err_n, 0);
        chk("idle_overrun", ovr_n, 0);
        chk("idle_valid", {31'd0, dout_valid}, {31'd0, m_valid});
        chk("idle_dout", {24'd0, dout}, {24'd0, m_dout});
    endtask

    initial begin
        int r;
        int kind;
        int gap;

        m_valid = 1'b0;
        m_dout  = '0;
        m_cnt   = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        clr = 1'b1;

        // Basic frame 1,0,1,1,0,0,1,0 with load in first low cycle
        do_frame(0, 8'hB2, 0, 1'b0);
        chk("basic_not_valid_before_commit", {31'd0, valid_after_bits}, 32'd0);
        idle(1'b1);

        // Short and long frames
        err_n = 0; err_at = -1;
        run_frame(16'h0055, 7, 1, -1, 1'b0);
        chk("short7_err_count", err_n, 1);
        chk("short7_valid", {31'd0, dout_valid}, 32'd0);
        run_frame(16'h02D3, 10, 1, -1, 1'b0);
        chk("long10_err_count", err_n, 1);
        chk("long10_err_at_9th", err_at, N);
        chk("long10_valid", {31'd0, dout_valid}, 32'd0);
        chk("long10_word_cnt", {16'd0, word_cnt}, 32'd1);

        // Load timeout, then a good frame
        do_frame(3, 8'hA5, 0, 1'b0);
        do_frame(0, 8'h5A, 0, 1'b0);

        // Overrun and simultaneous accept
        do_frame(0, 8'h11, 0, 1'b1);
        do_frame(0, 8'h22, 1, 1'b0);
        do_frame(0, 8'h22, 2, 1'b1);

        // Back-to-back frames with no idle gap
        do_frame(0, 8'h3C, 0, 1'b1);
        do_frame(0, 8'h5E, 0, 1'b1);
        do_frame(0, 8'h71, 0, 1'b1);

        // Word counter wrap
        force dut.word_cnt_q = 16'hFFFF;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        release dut.word_cnt_q;
        m_cnt = 16'hFFFF;
        chk("wrap_preload", {16'd0, word_cnt}, 32'h0000FFFF);
        do_frame(0, 8'h77, 0, 1'b1);
        chk("wrap_to_zero", {16'd0, word_cnt}, 32'd1 - 32'd1);

        // Randomized frames and gaps
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(9, 0);
            kind = (r < 6) ? 0 : ((r == 9) ? 0 : r - 5);
            do_frame(kind, 8'($urandom), $urandom_range(LD_TO - 1, 0), 1'($urandom));
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) idle(1'($urandom));
        end

        // Async reset in the middle of a frame
        do_frame(0, 8'h96, 0, 1'b1);
        chk("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            pos = i;
            cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        end
        #2;
        clr = 1'b0;
        #1;
        chk("async_rst_dout", {24'd0, dout}, 32'd0);
        chk("async_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("async_rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("async_rst_frame_err", {31'd0, frame_err}, 32'd0);
        m_valid = 1'b0;
        m_dout  = '0;
        m_cnt   = '0;
        @(negedge clk);
        clr = 1'b1;
        // data_mark still high at release: remaining bits form a short frame
        run_frame(16'h000A, 4, 1, -1, 1'b0);
        chk("post_rst_short_err", err_n, 1);
        chk("post_rst_short_at", err_at, 100);
        do_frame(0, 8'hC3, 0, 1'b0);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adc_serial_rx.md
# adc_serial_rx

Serial receiver for the ADC controller's serial result stream. It is the far end of the link driven by the controller's SerialOutput / DataMark / LoadReg outputs. It deserializes one MSB-first frame per conversion, checks the frame length and the LoadReg commit strobe, and presents the word on a valid/ready output with overrun and framing-error reporting. It sits in the consumer logic (host interface or test logic) and is clocked by the same clk as the controller.

## Interface
- N, 8: bits per frame / output word width
- LD_TIMEOUT, 4: cycles after DataMark falls within which load_reg must arrive; 1..15
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  asynchronous active-low reset
- serial_in  in  1  serial data bit, MSB first, valid while data_mark=1
- data_mark  in  1  frame qualifier; one bit per clk while high
- load_reg  in  1  single-cycle commit strobe that ends a frame
- dout  out  N  received word
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
- frame_err  out  1  one-cycle pulse: bad frame, word discarded
- overrun  out  1  one-cycle pulse: good frame dropped because output still full
- word_cnt  out  16  count of delivered words, wraps at 2^16

## Operation
- All inputs are synchronous to clk and are not resynchronized.
- FSM states: IDLE, SHIFT, WAIT_LD, DRAIN.
- IDLE:
  - data_mark=1 → shift_reg={shift_reg[N-2:0],serial_in}, bit_cnt=1, go SHIFT.
  - load_reg=1 while in IDLE is ignored.
- SHIFT, data_mark=1:
  - bit_cnt<N → shift in the bit, bit_cnt++.
  - bit_cnt==N → the frame is too long: pulse frame_err, go DRAIN.
- SHIFT, data_mark=0:
  - bit_cnt==N → go WAIT_LD, timer=0. If load_reg=1 in this same cycle, commit immediately and go IDLE.
  - bit_cnt≠N → the frame is short: pulse frame_err, go IDLE.
- WAIT_LD:
  - load_reg=1 → commit, go IDLE.
  - data_mark=1 before the commit → pulse frame_err, go IDLE. The bit on serial_in is not captured.
  - Timer increments each cycle. When timer reaches LD_TIMEOUT → pulse frame_err, go IDLE.
- DRAIN: stay until data_mark=0, then go IDLE. No further error pulses and no capture while draining.
- Commit:
  - If dout_valid=0, or (dout_valid=1 && dout_ready=1) in the same cycle: dout←shift_reg, dout_valid←1, word_cnt++.
  - Otherwise: pulse overrun. dout and dout_valid are unchanged and the new word is lost.
- Consume: dout_valid && dout_ready with no commit in that cycle → dout_valid←0. dout holds its last value.
- frame_err and overrun are mutually exclusive in any one cycle.

## Timing
- Reset (clr=0, asynchronous): state=IDLE, shift_reg=0, bit_cnt=0, timer=0, dout=0, dout_valid=0, frame_err=0, overrun=0, word_cnt=0.
- Reset deasserted mid-frame: the receiver starts in IDLE. If data_mark is already high at release, the next bit starts a new frame, which is then normally short and yields frame_err.
- Latency: the commit edge is the clk edge on which load_reg=1 is sampled in SHIFT (at frame end) or WAIT_LD. On that edge dout and dout_valid update, and word_cnt updates on the same edge.
- A minimum frame (N cycles of data_mark, load_reg in the first low cycle) gives dout_valid 1 cycle after the last data bit's edge.
- Back-to-back frames: a new data_mark may start in the cycle immediately after the commit (IDLE accepts it).
- frame_err and overrun are high for exactly one cycle, on the clock edge that registers the condition.
- dout is stable while dout_valid=1 and not yet consumed.

## Test plan
- Basic frame: after reset, drive data_mark=1 for 8 cycles with serial_in 1,0,1,1,0,0,1,0, then one cycle of data_mark=0 with load_reg=1 → dout=0xB2, dout_valid=1 on the next edge, word_cnt=1, no error pulses.
- Short and long frames:
  - 7 bits then data_mark low → frame_err pulses once, dout_valid stays 0.
  - 10 bits → frame_err pulses on the 9th bit, FSM stays in DRAIN until data_mark falls, no commit.
- Timeout: a good 8-bit frame with load_reg never asserted → frame_err exactly LD_TIMEOUT cycles after data_mark falls. A later good frame (0x5A) then delivers correctly.
- Overrun and simultaneous accept:
  - Hold dout_ready=0 after 0x11 is delivered, send frame 0x22 → overrun pulses and dout stays 0x11.
  - Repeat with dout_ready=1 on the commit cycle → dout=0x22, dout_valid stays 1, no overrun.
- Back-to-back frames and wrap: 3 consecutive frames with zero idle gap, dout_ready=1 → three words delivered in order. Preload word_cnt to 0xFFFF via 65535 frames (or force) → the next commit wraps it to 0.
- Async reset mid-frame: assert clr=0 after 4 bits → all outputs 0 immediately, without waiting for a clk edge. Release it and send a full frame 0xC3 → dout=0xC3 delivered.
